adc_frame_tx: RTL and testbench

ADC_FRAME_TX -- requirements
Module: adc_frame_tx

---
 rtl/adc_tx_pkg.sv | 21 ++
 rtl/adc_frame_tx_if.sv | 17 +
 rtl/word_rotator.sv | 19 +
 rtl/adc_frame_tx.sv | 186 ++++++++++++++++++
 tb/tb_adc_frame_tx.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_tx_pkg
// Brief   : Shared state encoding and default word patterns for adc_frame_tx.
// Revision: 1.0 - initial release
// ============================================================================
package adc_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DATA  = 2'd2
    } tx_state_t;

    localparam logic [7:0] c_frame_pattern = 8'hF0;
    localparam logic [7:0] c_train_word    = 8'h5A;
    localparam logic [7:0] c_idle_word     = 8'h00;
    localparam int         c_fifo_depth    = 4;

endpackage
`default_nettype wire

// File: rtl/adc_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : adc_frame_tx_if
// Brief   : Valid/ready sample-word stream feeding the frame transmitter.
// Revision: 1.0 - initial release
// ============================================================================
interface adc_frame_tx_if #(
    parameter int LANES = 2
);
    logic [8*LANES-1:0] s_data;
    logic               s_valid;
    logic               s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/word_rotator.sv
`default_nettype none
// ============================================================================
// Module  : word_rotator
// Brief   : Selects an 8-bit window from {cur, prev} to emulate bit slip.
// Revision: 1.0 - initial release
// ============================================================================
module word_rotator (
    input  wire logic [7:0] cur,
    input  wire logic [7:0] prev,
    input  wire logic [2:0] rot,
    output logic      [7:0] out
);
    logic [15:0] w_shifted;

    // Shifting left by rot puts bits [15-rot:8-rot] into the top byte.
    assign w_shifted = {cur, prev} << rot;
    assign out       = w_shifted[15:8];
endmodule
`default_nettype wire

// File: rtl/adc_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : adc_frame_tx
// Brief   : Frame/data word generator with training, 4-deep FIFO and bit slip.
// Revision: 1.0 - initial release
// ============================================================================
module adc_frame_tx
    import adc_tx_pkg::*;
#(
    parameter int         LANES         = 2,
    parameter logic [7:0] FRAME_PATTERN = c_frame_pattern,
    parameter logic [7:0] TRAIN_WORD    = c_train_word,
    parameter logic [7:0] IDLE_WORD     = c_idle_word
) (
    input  wire logic               divclk,
    input  wire logic               rst_n,
    input  wire logic               en,
    input  wire logic               train_req,
    input  wire logic [7:0]         train_len,
    input  wire logic               slip_inj,
    adc_frame_tx_if.slave           s_if,
    output logic      [7:0]         fclk_par,
    output logic      [8*LANES-1:0] data_par,
    output logic                    ser_oe,
    output logic      [1:0]         state,
    output logic      [2:0]         rot,
    output logic      [15:0]        underrun_cnt
);
    tx_state_t          r_state;
    logic [7:0]         r_frame_cnt;
    logic [8*LANES-1:0] r_fifo [0:c_fifo_depth-1];
    logic [1:0]         r_wr_ptr;
    logic [1:0]         r_rd_ptr;
    logic [2:0]         r_count;
    logic [15:0]        r_underrun;
    logic [2:0]         r_rot;
    logic [7:0]         r_prev_fclk;
    logic [8*LANES-1:0] r_prev_data;
    logic [7:0]         r_fclk_par;
    logic [8*LANES-1:0] r_data_par;
    logic               r_ser_oe;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_live;
    logic               w_data_cycle;
    logic [7:0]         w_raw_fclk;
    logic [8*LANES-1:0] w_raw_data;
    logic [7:0]         w_fclk_rot;
    logic [8*LANES-1:0] w_data_rot;

    assign w_ready      = (r_count < 3'(c_fifo_depth)) && (r_state != ST_IDLE);
    assign w_push       = s_if.s_valid && w_ready;
    assign w_empty      = (r_count == 3'd0);
    // A cycle with en low already behaves as IDLE so no word leaks past the drop.
    assign w_live       = en && (r_state != ST_IDLE);
    assign w_data_cycle = en && (r_state == ST_DATA);
    assign w_pop        = w_data_cycle && !w_empty;
    assign s_if.s_ready = w_ready;

    always_comb begin
        w_raw_fclk = 8'h00;
        w_raw_data = '0;
        if (en && (r_state == ST_TRAIN)) begin
            w_raw_fclk = FRAME_PATTERN;
            w_raw_data = {LANES{TRAIN_WORD}};
        end else if (w_data_cycle) begin
            w_raw_fclk = FRAME_PATTERN;
            w_raw_data = w_empty ? {LANES{IDLE_WORD}} : r_fifo[r_rd_ptr];
        end
    end

    always_ff @(posedge divclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= 8'd0;
        end else if (!en) begin
            r_state     <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_TRAIN;
                    r_frame_cnt <= 8'd0;
                end
                ST_TRAIN: begin
                    if (train_req) begin
                        r_frame_cnt <= 8'd0;
                    end else if (r_frame_cnt == train_len) begin
                        r_state     <= ST_DATA;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (train_req) begin
                        r_state     <= ST_TRAIN;
                        r_frame_cnt <= 8'd0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge divclk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= s_if.s_data;
        end
    end

    always_ff @(posedge divclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else if (!en) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge divclk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 16'h0000;
            r_rot      <= 3'd0;
        end else begin
            if (w_data_cycle && w_empty && (r_underrun != 16'hFFFF)) begin
                r_underrun <= r_underrun + 16'd1;
            end
            if (slip_inj) begin
                r_rot <= r_rot + 3'd1;
            end
        end
    end

    word_rotator u_fclk_rot (
        .cur  (w_raw_fclk),
        .prev (r_prev_fclk),
        .rot  (r_rot),
        .out  (w_fclk_rot)
    );

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        word_rotator u_lane_rot (
            .cur  (w_raw_data[8*gi +: 8]),
            .prev (r_prev_data[8*gi +: 8]),
            .rot  (r_rot),
            .out  (w_data_rot[8*gi +: 8])
        );
    end

    always_ff @(posedge divclk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_fclk <= 8'h00;
            r_prev_data <= '0;
            r_fclk_par  <= 8'h00;
            r_data_par  <= '0;
            r_ser_oe    <= 1'b0;
        end else begin
            r_prev_fclk <= w_raw_fclk;
            r_prev_data <= w_raw_data;
            r_fclk_par  <= w_fclk_rot;
            r_data_par  <= w_data_rot;
            r_ser_oe    <= w_live;
        end
    end

    assign fclk_par     = r_fclk_par;
    assign data_par     = r_data_par;
    assign ser_oe       = r_ser_oe;
    assign state        = r_state;
    assign rot          = r_rot;
    assign underrun_cnt = r_underrun;
endmodule
`default_nettype wire

// File: tb/tb_adc_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_frame_tx
// Brief   : Directed plus randomized bench for adc_frame_tx with a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adc_frame_tx;
    localparam int LANES = 2;

    logic        divclk    = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en        = 1'b0;
    logic        train_req = 1'b0;
    logic [7:0]  train_len = 8'd0;
    logic        slip_inj  = 1'b0;
    logic [7:0]  fclk_par;
    logic [15:0] data_par;
    logic        ser_oe;
    logic [1:0]  state;
    logic [2:0]  rot;
    logic [15:0] underrun_cnt;

    adc_frame_tx_if #(.LANES(LANES)) bus ();

    adc_frame_tx #(.LANES(LANES)) dut (
        .divclk       (divclk),
        .rst_n        (rst_n),
        .en           (en),
        .train_req    (train_req),
        .train_len    (train_len),
        .slip_inj     (slip_inj),
        .s_if         (bus),
        .fclk_par     (fclk_par),
        .data_par     (data_par),
        .ser_oe       (ser_oe),
        .state        (state),
        .rot          (rot),
        .underrun_cnt (underrun_cnt)
    );

    always #5 divclk = ~divclk;

    // Reference model: 0=IDLE 1=TRAIN 2=DATA, FIFO as a queue.
    int          checks;
    int          failures;
    int          m_state;
    int          m_frames;
    int          m_under;
    int          m_rot;
    logic [15:0] m_q[$];
    logic [7:0]  m_prev_f;
    logic [15:0] m_prev_d;
    logic [7:0]  e_fclk;
    logic [15:0] e_data;
    logic        e_oe;

    function automatic logic [7:0] rotw(input logic [7:0] c, input logic [7:0] p, input int r);
        logic [15:0] w;
        w = {c, p};
        w = w >> (8 - r);
        return w[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_frames = 0;
        m_under  = 0;
        m_rot    = 0;
        m_q.delete();
        m_prev_f = 8'h00;
        m_prev_d = 16'h0000;
        e_fclk   = 8'h00;
        e_data   = 16'h0000;
        e_oe     = 1'b0;
    endtask

    task automatic check_all();
        check("state",    32'(state),        32'(m_state));
        check("rot",      32'(rot),          32'(m_rot));
        check("underrun", 32'(underrun_cnt), 32'(m_under));
        check("fclk_par", 32'(fclk_par),     32'(e_fclk));
        check("data_par", 32'(data_par),     32'(e_data));
        check("ser_oe",   32'(ser_oe),       32'(e_oe));
    endtask

    task automatic step();
        logic [7:0]  rf;
        logic [15:0] rd;
        logic        ready;
        ready = (m_q.size() < 4) && (m_state != 0);
        check("s_ready", 32'(bus.s_ready), 32'(ready));
        rf = 8'h00;
        rd = 16'h0000;
        if (en && m_state == 1) begin
            rf = 8'hF0;
            rd = 16'h5A5A;
        end else if (en && m_state == 2) begin
            rf = 8'hF0;
            if (m_q.size() > 0) rd = m_q.pop_front();
            else if (m_under < 65535) m_under++;
        end
        if (bus.s_valid && ready) m_q.push_back(bus.s_data);
        e_fclk   = rotw(rf, m_prev_f, m_rot);
        e_data   = {rotw(rd[15:8], m_prev_d[15:8], m_rot), rotw(rd[7:0], m_prev_d[7:0], m_rot)};
        e_oe     = en && (m_state != 0);
        m_prev_f = rf;
        m_prev_d = rd;
        if (slip_inj) m_rot = (m_rot + 1) % 8;
        if (!en) begin
            m_state = 0;
            m_q.delete();
        end else if (m_state == 0) begin
            m_state  = 1;
            m_frames = 0;
        end else if (m_state == 1) begin
            if (train_req) m_frames = 0;
            else if (m_frames + 1 == int'(train_len) + 1) m_state = 2;
            else m_frames++;
        end else if (train_req) begin
            m_state  = 1;
            m_frames = 0;
        end
        @(posedge divclk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        slip_inj  = 1'b0;
        train_req = 1'b0;
        rst_n     = 1'b0;
        #2;
        model_reset();
        check_all();
        check("reset_ready", 32'(bus.s_ready), 32'd0);
        @(posedge divclk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        bus.s_valid = 1'b0;
        bus.s_data  = 16'h0000;
        model_reset();

        // Reset values
        #2;
        check_all();
        check("reset_ready", 32'(bus.s_ready), 32'd0);
        @(posedge divclk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Training burst of four frames, then empty DATA
        en = 1'b1;
        train_len = 8'd3;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("train_fclk", 32'(fclk_par), 32'h0000_00F0);
            check("train_data", 32'(data_par), 32'h0000_5A5A);
        end
        check("enter_data", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("under_data", 32'(data_par), 32'h0000_0000);
            check("under_cnt", 32'(underrun_cnt), 32'(i + 1));
        end

        // Back-to-back pushes, two-cycle latency
        bus.s_valid = 1'b1;
        bus.s_data = 16'h1122; step();
        bus.s_data = 16'h3344; step();
        check("lat_1122", 32'(data_par), 32'h0000_1122);
        bus.s_data = 16'h5566; step();
        check("lat_3344", 32'(data_par), 32'h0000_3344);
        bus.s_valid = 1'b0;
        step();
        check("lat_5566", 32'(data_par), 32'h0000_5566);
        check("lat_fclk", 32'(fclk_par), 32'h0000_00F0);
        step();

        // Fill the FIFO while training is held, then drain
        train_req = 1'b1;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.s_data = 16'($urandom);
            step();
        end
        check("full_ready", 32'(bus.s_ready), 32'd0);
        check("full_state", 32'(state), 32'd1);
        train_req = 1'b0;
        bus.s_valid = 1'b0;
        train_len = 8'd1;
        repeat (10) step();

        // Bit slip on constant AB data
        bus.s_valid = 1'b1;
        bus.s_data = 16'hABAB;
        repeat (4) step();
        check("pre_slip", 32'(data_par), 32'h0000_ABAB);
        slip_inj = 1'b1; step();
        slip_inj = 1'b0;
        check("slip_rot", 32'(rot), 32'd1);
        step();
        check("slip_fclk", 32'(fclk_par), 32'h0000_00E1);
        check("slip_data", 32'(data_par), 32'h0000_5757);
        for (int i = 0; i < 7; i++) begin
            slip_inj = 1'b1; step();
            slip_inj = 1'b0; step();
        end
        check("wrap_rot", 32'(rot), 32'd0);
        check("wrap_fclk", 32'(fclk_par), 32'h0000_00F0);
        check("wrap_data", 32'(data_par), 32'h0000_ABAB);

        // Drop enable with three queued entries
        bus.s_valid = 1'b0;
        step();
        train_req = 1'b1; step();
        train_req = 1'b0;
        train_len = 8'd20;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.s_data = 16'($urandom);
            step();
        end
        bus.s_valid = 1'b0;
        en = 1'b0;
        step();
        check("drop_state", 32'(state), 32'd0);
        check("drop_oe", 32'(ser_oe), 32'd0);
        check("drop_fclk", 32'(fclk_par), 32'd0);
        check("drop_data", 32'(data_par), 32'd0);
        check("drop_ready", 32'(bus.s_ready), 32'd0);
        en = 1'b1;
        train_len = 8'd0;
        step();
        step();
        step();
        check("reen_state", 32'(state), 32'd2);
        check("reen_data", 32'(data_par), 32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en          = ($urandom_range(0, 19) != 0);
            train_req   = ($urandom_range(0, 24) == 0);
            slip_inj    = ($urandom_range(0, 9) == 0);
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = 16'($urandom);
            if (m_state == 0) train_len = 8'($urandom_range(0, 5));
            step();
        end
        train_req   = 1'b0;
        slip_inj    = 1'b0;
        bus.s_valid = 1'b0;

        // Reset in the middle of a loaded training burst
        en = 1'b1;
        train_len = 8'd30;
        repeat (2) step();
        train_req = 1'b1; step();
        train_req = 1'b0;
        bus.s_valid = 1'b1;
        repeat (3) begin
            bus.s_data = 16'($urandom);
            step();
        end
        bus.s_valid = 1'b0;
        do_reset();
        train_len = 8'd2;
        repeat (8) step();
        check("post_rst_data", 32'(data_par), 32'h0000_0000);

        // Underrun counter saturation
        do_reset();
        train_len = 8'd0;
        repeat (65540) step();
        check("sat_cnt", 32'(underrun_cnt), 32'h0000_FFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat_hold", 32'(underrun_cnt), 32'h0000_FFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
